// File: rtl/note_rec_pkg.sv
// Shared definitions for the note recorder: note code constants and FSM state encoding.
// RAM entries are packed {note[NOTE_W-1:0], dur[DUR_W-1:0]} with the note in the upper bits.
package note_rec_pkg;

  localparam int NOTE_W = 5;
  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REC   = 2'd1,
    FETCH = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/note_rec_ram.sv
// Entry store for the note recorder: one write port, one registered read port, no reset.
module note_rec_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/note_recorder.sv
// Records the live note stream as {note, duration} runs and replays them as a note stream.
// Define NOTE_RECORDER_LOOP_EN to make playback wrap to the first entry until stopped.
module note_recorder
  import note_rec_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 500000,
  parameter int DUR_W    = 8
) (
  input  logic                   CLK,
  input  logic                   nCLR,
  input  logic [NOTE_W-1:0]      note_in,
  input  logic                   rec_req,
  input  logic                   play_req,
  input  logic                   stop_req,
  output logic [NOTE_W-1:0]      note_out,
  output logic                   recording,
  output logic                   playing,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = NOTE_W + DUR_W;
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX    = '1;
  localparam logic [AW:0]      CNT_MAX    = (AW+1)'(DEPTH);
`ifdef NOTE_RECORDER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_t             state;
  logic [PW-1:0]      presc;
  logic [NOTE_W-1:0]  cur_note;
  logic [DUR_W-1:0]   cur_dur;
  logic [DUR_W-1:0]   remaining;
  logic [AW-1:0]      idx;
  logic               tick, extend, pending, room, more;
  logic               start_rec, start_play, rec_tick, overflow;
  logic               load, hold_tick, run_end;
  logic               wr_en, rd_en;
  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] wr_data, rd_data;

  assign tick    = (presc == PRESC_LAST);
  assign extend  = (note_in == cur_note) && (cur_dur != DUR_MAX);
  assign pending = (cur_dur != '0);
  assign room    = (count < CNT_MAX);
  assign more    = ((AW+1)'(idx) + (AW+1)'(1)) < count;

  // stop > rec > play; requests a state does not list are simply not decoded there
  assign start_rec  = (state == IDLE) && !stop_req && rec_req;
  assign start_play = (state == IDLE) && !stop_req && !rec_req && play_req && (count != '0);
  assign rec_tick   = (state == REC) && !stop_req && tick;
  assign overflow   = rec_tick && !extend && pending && !room;
  assign wr_en      = (state == REC) && pending && room && (stop_req || (tick && !extend));
  assign load       = (state == FETCH) && !stop_req;
  assign hold_tick  = (state == HOLD) && !stop_req && tick;
  assign run_end    = hold_tick && (remaining == DUR_W'(1));

  // The read is launched on the edge that enters FETCH so the data is ready for the HOLD load
  assign rd_en   = start_play || (run_end && (more || LOOP_EN));
  assign rd_addr = (run_end && more) ? idx + AW'(1) : '0;
  assign wr_data = {cur_note, cur_dur};

  note_rec_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) ram (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (count[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge CLK) begin
    if (start_rec) begin
      cur_note <= note_in;
      cur_dur  <= '0;
    end else if (rec_tick) begin
      if (extend) begin
        cur_dur <= cur_dur + DUR_W'(1);
      end else begin
        cur_note <= note_in;
        cur_dur  <= DUR_W'(1);
      end
    end
    if (start_play)   idx <= '0;
    else if (run_end) idx <= more ? idx + AW'(1) : '0;
    if (load)           remaining <= rd_data[DUR_W-1:0];
    else if (hold_tick) remaining <= remaining - DUR_W'(1);
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state     <= IDLE;
      presc     <= '0;
      note_out  <= NOTE_REST;
      recording <= 1'b0;
      playing   <= 1'b0;
      full      <= 1'b0;
      count     <= '0;
    end else begin
      if (start_rec || load || tick) presc <= '0;
      else                           presc <= presc + PW'(1);
      if (wr_en) count <= count + (AW+1)'(1);
      case (state)
        IDLE: begin
          if (start_rec) begin
            state     <= REC;
            recording <= 1'b1;
            count     <= '0;
            full      <= 1'b0;
          end else if (start_play) begin
            state   <= FETCH;
            playing <= 1'b1;
          end
        end
        REC: begin
          if (stop_req) begin
            state     <= IDLE;
            recording <= 1'b0;
          end else if (overflow) begin
            full      <= 1'b1;
            state     <= IDLE;
            recording <= 1'b0;
          end
        end
        FETCH: begin
          if (stop_req) begin
            state    <= IDLE;
            playing  <= 1'b0;
            note_out <= NOTE_REST;
          end else begin
            state    <= HOLD;
            note_out <= rd_data[ENTRY_W-1:DUR_W];
          end
        end
        HOLD: begin
          if (stop_req) begin
            state    <= IDLE;
            playing  <= 1'b0;
            note_out <= NOTE_REST;
          end else if (run_end) begin
            if (more || LOOP_EN) begin
              state <= FETCH;
            end else begin
              state    <= IDLE;
              playing  <= 1'b0;
              note_out <= NOTE_REST;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder (DEPTH=4, TICK_DIV=4, DUR_W=4); honours NOTE_RECORDER_LOOP_EN.
module tb_note_recorder;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          CLK  = 1'b0;
  logic          nCLR = 1'b1;
  logic [4:0]    note_in  = 5'd21;
  logic          rec_req  = 1'b0;
  logic          play_req = 1'b0;
  logic          stop_req = 1'b0;
  logic [4:0]    note_out;
  logic          recording, playing, full;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  note_recorder #(
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV),
    .DUR_W    (DUR_W)
  ) dut (
    .CLK       (CLK),
    .nCLR      (nCLR),
    .note_in   (note_in),
    .rec_req   (rec_req),
    .play_req  (play_req),
    .stop_req  (stop_req),
    .note_out  (note_out),
    .recording (recording),
    .playing   (playing),
    .full      (full),
    .count     (count)
  );

  always #5 CLK = ~CLK;

  // Each record holds its inputs for reps cycles and checks the outputs after every edge
  typedef struct {
    int            seg;
    logic [4:0]    note;
    logic          rec, play, stop;
    int            reps;
    logic [4:0]    e_note;
    logic          e_rec, e_play, e_full;
    logic [CW-1:0] e_count;
    logic [127:0]  name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int seg, input int note, input bit rec, input bit play,
                              input bit stop, input int reps, input int e_note, input bit e_rec,
                              input bit e_play, input bit e_full, input int e_count,
                              input logic [127:0] name);
    vec_t v;
    v.seg = seg; v.note = 5'(note); v.rec = rec; v.play = play; v.stop = stop; v.reps = reps;
    v.e_note = 5'(e_note); v.e_rec = e_rec; v.e_play = e_play; v.e_full = e_full;
    v.e_count = CW'(e_count); v.name = name;
    vecs.push_back(v);
  endfunction

  // Close a playback segment: a looping build needs an explicit stop, a single pass just ends
  function automatic void add_end(input int seg, input int cnt, input bit f, input logic [127:0] name);
`ifdef NOTE_RECORDER_LOOP_EN
    add(seg, 21, 0, 0, 1, 1, 21, 0, 0, f, cnt, name);
    add(seg, 21, 0, 0, 0, 1, 21, 0, 0, f, cnt, name);
`else
    add(seg, 21, 0, 0, 0, 2, 21, 0, 0, f, cnt, name);
`endif
  endfunction

  task automatic check_out(input logic [127:0] name, input logic [4:0] e_note, input logic e_rec,
                           input logic e_play, input logic e_full, input logic [CW-1:0] e_count);
    n_checks++;
    if ({note_out, recording, playing, full, count} !== {e_note, e_rec, e_play, e_full, e_count}) begin
      n_fail++;
      $display("FAIL %0s @%0t: note_out=%0d recording=%b playing=%b full=%b count=%0d, expected note_out=%0d recording=%b playing=%b full=%b count=%0d",
               name, $time, note_out, recording, playing, full, count,
               e_note, e_rec, e_play, e_full, e_count);
    end
  endtask

  task automatic run_seg(input int seg);
    foreach (vecs[i]) begin
      if (vecs[i].seg == seg) begin
        note_in  = vecs[i].note;
        rec_req  = vecs[i].rec;
        play_req = vecs[i].play;
        stop_req = vecs[i].stop;
        for (int r = 0; r < vecs[i].reps; r++) begin
          @(posedge CLK); #1;
          check_out(vecs[i].name, vecs[i].e_note, vecs[i].e_rec, vecs[i].e_play,
                    vecs[i].e_full, vecs[i].e_count);
        end
      end
    end
  endtask

  initial begin
    // seg 0: record {7,3},{9,2} then replay both entries
    add(0,  7, 1, 0, 0,  1, 21, 1, 0, 0, 0, "rec_start");
    add(0,  7, 0, 0, 0, 14, 21, 1, 0, 0, 0, "rec_run7");
    add(0,  9, 0, 0, 0,  1, 21, 1, 0, 0, 0, "rec_to9");
    add(0,  9, 0, 0, 0,  6, 21, 1, 0, 0, 1, "rec_run9");
    add(0,  9, 0, 0, 1,  1, 21, 0, 0, 0, 2, "rec_stop");
    add(0, 21, 0, 1, 0,  1, 21, 0, 1, 0, 2, "play_fetch");
    add(0, 21, 0, 0, 0, 13,  7, 0, 1, 0, 2, "play_7");
    add(0, 21, 0, 0, 0,  8,  9, 0, 1, 0, 2, "play_9");
    add_end(0, 2, 0, "play_end");
    // seg 1: empty play ignored, rec beats play, stop with nothing pending
    add(1,  3, 0, 1, 0,  1, 21, 0, 0, 0, 0, "play_empty");
    add(1,  3, 1, 1, 0,  1, 21, 1, 0, 0, 0, "rec_play_pri");
    add(1,  3, 0, 0, 1,  1, 21, 0, 0, 0, 0, "stop_nodata");
    add(1,  3, 0, 0, 0,  1, 21, 0, 0, 0, 0, "idle_after");
    // seg 2: 20-tick run of 11 splits into {11,15},{11,5}
    add(2, 11, 1, 0, 0,  1, 21, 1, 0, 0, 0, "sat_start");
    add(2, 11, 0, 0, 0, 63, 21, 1, 0, 0, 0, "sat_run");
    add(2, 11, 0, 0, 0, 18, 21, 1, 0, 0, 1, "sat_split");
    add(2, 11, 0, 0, 1,  1, 21, 0, 0, 0, 2, "sat_stop");
    add(2, 21, 0, 1, 0,  1, 21, 0, 1, 0, 2, "sat_fetch");
    add(2, 21, 0, 0, 0, 81, 11, 0, 1, 0, 2, "sat_play");
    add_end(2, 2, 0, "sat_end");
    // seg 3: one-tick runs 1..6; the write of run 5 overflows
    add(3,  1, 1, 0, 0,  1, 21, 1, 0, 0, 0, "ovf_start");
    add(3,  1, 0, 0, 0,  4, 21, 1, 0, 0, 0, "ovf_r1");
    add(3,  2, 0, 0, 0,  3, 21, 1, 0, 0, 0, "ovf_r2");
    add(3,  2, 0, 0, 0,  1, 21, 1, 0, 0, 1, "ovf_w1");
    add(3,  3, 0, 0, 0,  3, 21, 1, 0, 0, 1, "ovf_r3");
    add(3,  3, 0, 0, 0,  1, 21, 1, 0, 0, 2, "ovf_w2");
    add(3,  4, 0, 0, 0,  3, 21, 1, 0, 0, 2, "ovf_r4");
    add(3,  4, 0, 0, 0,  1, 21, 1, 0, 0, 3, "ovf_w3");
    add(3,  5, 0, 0, 0,  3, 21, 1, 0, 0, 3, "ovf_r5");
    add(3,  5, 0, 0, 0,  1, 21, 1, 0, 0, 4, "ovf_w4");
    add(3,  6, 0, 0, 0,  3, 21, 1, 0, 0, 4, "ovf_r6");
    add(3,  6, 0, 0, 0,  1, 21, 0, 0, 1, 4, "ovf_full");
    add(3,  6, 0, 0, 0,  2, 21, 0, 0, 1, 4, "ovf_idle");
    add(3, 21, 0, 1, 0,  1, 21, 0, 1, 1, 4, "ovf_fetch");
    add(3, 21, 0, 0, 0,  5,  1, 0, 1, 1, 4, "ovf_p1");
    add(3, 21, 0, 0, 0,  5,  2, 0, 1, 1, 4, "ovf_p2");
    add(3, 21, 0, 0, 0,  5,  3, 0, 1, 1, 4, "ovf_p3");
    add(3, 21, 0, 0, 0,  4,  4, 0, 1, 1, 4, "ovf_p4");
    add_end(3, 4, 1, "ovf_end");
    // seg 4: single entry {5,2}: one pass, or repeats when looping
    add(4,  5, 1, 0, 0,  1, 21, 1, 0, 0, 0, "one_start");
    add(4,  5, 0, 0, 0,  8, 21, 1, 0, 0, 0, "one_run");
    add(4,  5, 0, 0, 1,  1, 21, 0, 0, 0, 1, "one_stop");
    add(4, 21, 0, 1, 0,  1, 21, 0, 1, 0, 1, "one_fetch");
    add(4, 21, 0, 0, 0,  8,  5, 0, 1, 0, 1, "one_play");
`ifdef NOTE_RECORDER_LOOP_EN
    add(4, 21, 0, 0, 0, 19,  5, 0, 1, 0, 1, "loop_repeat");
`endif
    add_end(4, 1, 0, "one_end");

    #1 nCLR = 1'b0;
    #2 check_out("reset_async", 5'd21, 1'b0, 1'b0, 1'b0, '0);
    @(negedge CLK); nCLR = 1'b1;
    @(posedge CLK); #1;
    check_out("reset_idle", 5'd21, 1'b0, 1'b0, 1'b0, '0);

    run_seg(0);

    // stop together with rec during HOLD: stop wins, buffer kept
    play_req = 1'b1;
    @(posedge CLK); #1; play_req = 1'b0;
    check_out("hold_fetch", 5'd21, 1'b0, 1'b1, 1'b0, CW'(2));
    repeat (3) begin @(posedge CLK); #1; end
    check_out("hold_note", 5'd7, 1'b0, 1'b1, 1'b0, CW'(2));
    stop_req = 1'b1; rec_req = 1'b1; note_in = 5'd3;
    @(posedge CLK); #1; stop_req = 1'b0; rec_req = 1'b0;
    check_out("stop_rec_hold", 5'd21, 1'b0, 1'b0, 1'b0, CW'(2));
    @(posedge CLK); #1;
    check_out("after_stop", 5'd21, 1'b0, 1'b0, 1'b0, CW'(2));

    // asynchronous reset in the middle of HOLD
    play_req = 1'b1;
    @(posedge CLK); #1; play_req = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    check_out("pre_reset", 5'd7, 1'b0, 1'b1, 1'b0, CW'(2));
    nCLR = 1'b0;
    #2 check_out("mid_reset", 5'd21, 1'b0, 1'b0, 1'b0, '0);
    #3 nCLR = 1'b1;
    @(posedge CLK); #1;
    check_out("post_reset", 5'd21, 1'b0, 1'b0, 1'b0, '0);

    run_seg(1);
    run_seg(2);
    run_seg(3);
    run_seg(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
